// File: rtl/cii_starter_pkg.sv
// Shared constants for the DE1 starter top level.
// SEG7_LUT: active-low seven-segment codes for hex digits 0..F (bit0 = a ... bit6 = g).
// Tie-off constants: idle levels for the unused board interfaces.
package cii_starter_pkg;

  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG7_ZERO = 7'h40;

  // Inactive levels: control strobes are active-low, so idle is high.
  localparam logic TIE_HI = 1'b1;
  localparam logic TIE_LO = 1'b0;

  localparam int unsigned DRAM_ADDR_W = 12;
  localparam int unsigned DRAM_DQ_W   = 16;
  localparam int unsigned FL_ADDR_W   = 22;
  localparam int unsigned FL_DQ_W     = 8;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DQ_W   = 16;
  localparam int unsigned VGA_W       = 4;
  localparam int unsigned GPIO_W      = 36;

endpackage

// File: rtl/hex7seg.sv
// Registered hex-to-seven-segment decoder.
// Ports: clk, rst_n (async active-low), hex (4-bit digit), seg (7-bit active-low segments).
// seg resets to the "0" glyph.
module hex7seg
  import cii_starter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  logic [6:0] seg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG7_ZERO;
    end else begin
      seg_q <= SEG7_LUT[hex];
    end
  end

  assign seg = seg_q;

endmodule

// File: rtl/cii_starter_top.sv
// DE1 board top level: prescaled 16-bit counter shown on HEX3..HEX0 and LEDG,
// switches mirrored on LEDR, all other board interfaces parked inactive / high-Z.
// Clock: CLOCK_24[0]. Reset: KEY[0] (async assert, 2-flop synchronized release).
// SW[9] freezes prescaler and counter (2-flop synchronized).
module cii_starter_top
  import cii_starter_pkg::*;
#(
  parameter int unsigned PRESCALE = 24_000_000
) (
  input  logic [1:0]  CLOCK_24,
  input  logic [1:0]  CLOCK_27,
  input  logic        CLOCK_50,
  input  logic        EXT_CLOCK,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [7:0]  LEDG,
  output logic [9:0]  LEDR,
  output logic        UART_TXD,
  input  logic        UART_RXD,
  inout  wire  [DRAM_DQ_W-1:0] DRAM_DQ,
  output logic [DRAM_ADDR_W-1:0] DRAM_ADDR,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM,
  output logic        DRAM_WE_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CS_N,
  output logic        DRAM_BA_0,
  output logic        DRAM_BA_1,
  output logic        DRAM_CLK,
  output logic        DRAM_CKE,
  inout  wire  [FL_DQ_W-1:0] FL_DQ,
  output logic [FL_ADDR_W-1:0] FL_ADDR,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic        FL_OE_N,
  output logic        FL_CE_N,
  inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  inout  wire         SD_DAT,
  inout  wire         SD_DAT3,
  inout  wire         SD_CMD,
  output wire         SD_CLK,
  inout  wire         I2C_SDAT,
  output wire         I2C_SCLK,
  input  logic        PS2_DAT,
  input  logic        PS2_CLK,
  input  logic        TDI,
  input  logic        TCK,
  input  logic        TCS,
  output logic        TDO,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [VGA_W-1:0] VGA_R,
  output logic [VGA_W-1:0] VGA_G,
  output logic [VGA_W-1:0] VGA_B,
  inout  wire         AUD_ADCLRCK,
  input  logic        AUD_ADCDAT,
  inout  wire         AUD_DACLRCK,
  output wire         AUD_DACDAT,
  inout  wire         AUD_BCLK,
  output wire         AUD_XCK,
  inout  wire  [GPIO_W-1:0] GPIO_0,
  inout  wire  [GPIO_W-1:0] GPIO_1
);

  localparam logic [24:0] PreMax = 25'(PRESCALE - 1);

  logic clk;
  logic key_rst_n;
  assign clk       = CLOCK_24[0];
  assign key_rst_n = KEY[0];

  // Reset: asserts asynchronously, releases on the 2nd rising edge after KEY[0] rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge key_rst_n) begin
    if (!key_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0]  hold_sync_q;
  logic        hold;
  logic [24:0] pre_q, pre_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  ledg_q;
  logic        tick;

  assign hold = hold_sync_q[1];
  assign tick = !hold && (pre_q == PreMax);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!hold) begin
      if (tick) begin
        pre_d = '0;
        cnt_d = cnt_q + 16'd1;
      end else begin
        pre_d = pre_q + 25'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_sync_q <= 2'b00;
      pre_q       <= '0;
      cnt_q       <= '0;
      ledg_q      <= '0;
    end else begin
      hold_sync_q <= {hold_sync_q[0], SW[9]};
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      ledg_q      <= cnt_q[7:0];
    end
  end

  logic [6:0] hex_seg [4];

  for (genvar i = 0; i < 4; i++) begin : g_hex
    hex7seg u_hex7seg (
      .clk   (clk),
      .rst_n (rst_n),
      .hex   (cnt_q[4*i +: 4]),
      .seg   (hex_seg[i])
    );
  end

  assign HEX0 = hex_seg[0];
  assign HEX1 = hex_seg[1];
  assign HEX2 = hex_seg[2];
  assign HEX3 = hex_seg[3];
  assign LEDG = ledg_q;
  assign LEDR = SW;

  assign UART_TXD   = TIE_HI;
  assign TDO        = TIE_LO;
  assign VGA_HS     = TIE_LO;
  assign VGA_VS     = TIE_LO;
  assign VGA_R      = '0;
  assign VGA_G      = '0;
  assign VGA_B      = '0;
  assign DRAM_CS_N  = TIE_HI;
  assign DRAM_RAS_N = TIE_HI;
  assign DRAM_CAS_N = TIE_HI;
  assign DRAM_WE_N  = TIE_HI;
  assign DRAM_LDQM  = TIE_HI;
  assign DRAM_UDQM  = TIE_HI;
  assign DRAM_CKE   = TIE_LO;
  assign DRAM_CLK   = TIE_LO;
  assign DRAM_BA_0  = TIE_LO;
  assign DRAM_BA_1  = TIE_LO;
  assign DRAM_ADDR  = '0;
  assign FL_CE_N    = TIE_HI;
  assign FL_OE_N    = TIE_HI;
  assign FL_WE_N    = TIE_HI;
  assign FL_RST_N   = TIE_HI;
  assign FL_ADDR    = '0;
  assign SRAM_CE_N  = TIE_HI;
  assign SRAM_OE_N  = TIE_HI;
  assign SRAM_WE_N  = TIE_HI;
  assign SRAM_UB_N  = TIE_HI;
  assign SRAM_LB_N  = TIE_HI;
  assign SRAM_ADDR  = '0;

  assign DRAM_DQ     = 'z;
  assign FL_DQ       = 'z;
  assign SRAM_DQ     = 'z;
  assign SD_DAT      = 1'bz;
  assign SD_DAT3     = 1'bz;
  assign SD_CMD      = 1'bz;
  assign SD_CLK      = 1'bz;
  assign I2C_SDAT    = 1'bz;
  assign I2C_SCLK    = 1'bz;
  assign AUD_ADCLRCK = 1'bz;
  assign AUD_DACLRCK = 1'bz;
  assign AUD_DACDAT  = 1'bz;
  assign AUD_BCLK    = 1'bz;
  assign AUD_XCK     = 1'bz;
  assign GPIO_0      = 'z;
  assign GPIO_1      = 'z;

  logic unused_inputs;
  assign unused_inputs = ^{CLOCK_24[1], CLOCK_27, CLOCK_50, EXT_CLOCK, KEY[3:1], UART_RXD,
                           PS2_DAT, PS2_CLK, TDI, TCK, TCS, AUD_ADCDAT};

endmodule

// File: tb/tb_cii_starter_top.sv
// Bench for cii_starter_top: two instances (PRESCALE 4 and 1) driven by shared switches/reset,
// compared against an edge-counting reference model of the counter and display.
module tb_cii_starter_top;

  logic       clk;
  logic       key0;
  logic [9:0] sw;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: counted active edges; display reflects the value one edge older.
  int          rel;
  longint      ev;
  longint      disp_ev;
  logic [1:0]  hq;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Shared high-Z nets
  wire [15:0] dram_dq, sram_dq;
  wire [7:0]  fl_dq;
  wire [35:0] gpio_0, gpio_1;
  wire sd_dat, sd_dat3, sd_cmd, i2c_sdat, aud_adclrck, aud_daclrck, aud_bclk;
  wire sd_clk_a, i2c_sclk_a, aud_dacdat_a, aud_xck_a;
  wire sd_clk_b, i2c_sclk_b, aud_dacdat_b, aud_xck_b;

  // Instance A outputs
  logic [6:0] hex0_a, hex1_a, hex2_a, hex3_a;
  logic [7:0] ledg_a;
  logic [9:0] ledr_a;
  logic uart_txd_a, tdo_a, vga_hs_a, vga_vs_a;
  logic [3:0] vga_r_a, vga_g_a, vga_b_a;
  logic [11:0] dram_addr_a;
  logic dram_ldqm_a, dram_udqm_a, dram_we_n_a, dram_cas_n_a, dram_ras_n_a, dram_cs_n_a;
  logic dram_ba_0_a, dram_ba_1_a, dram_clk_a, dram_cke_a;
  logic [21:0] fl_addr_a;
  logic fl_we_n_a, fl_rst_n_a, fl_oe_n_a, fl_ce_n_a;
  logic [17:0] sram_addr_a;
  logic sram_ub_n_a, sram_lb_n_a, sram_we_n_a, sram_ce_n_a, sram_oe_n_a;

  // Instance B outputs
  logic [6:0] hex0_b, hex1_b, hex2_b, hex3_b;
  logic [7:0] ledg_b;
  logic [9:0] ledr_b;
  logic uart_txd_b, tdo_b, vga_hs_b, vga_vs_b;
  logic [3:0] vga_r_b, vga_g_b, vga_b_b;
  logic [11:0] dram_addr_b;
  logic dram_ldqm_b, dram_udqm_b, dram_we_n_b, dram_cas_n_b, dram_ras_n_b, dram_cs_n_b;
  logic dram_ba_0_b, dram_ba_1_b, dram_clk_b, dram_cke_b;
  logic [21:0] fl_addr_b;
  logic fl_we_n_b, fl_rst_n_b, fl_oe_n_b, fl_ce_n_b;
  logic [17:0] sram_addr_b;
  logic sram_ub_n_b, sram_lb_n_b, sram_we_n_b, sram_ce_n_b, sram_oe_n_b;

  cii_starter_top #(.PRESCALE(4)) u_dut_a (
    .CLOCK_24({1'b0, clk}), .CLOCK_27(2'b00), .CLOCK_50(1'b0), .EXT_CLOCK(1'b0),
    .KEY({3'b111, key0}), .SW(sw),
    .HEX0(hex0_a), .HEX1(hex1_a), .HEX2(hex2_a), .HEX3(hex3_a), .LEDG(ledg_a), .LEDR(ledr_a),
    .UART_TXD(uart_txd_a), .UART_RXD(1'b1),
    .DRAM_DQ(dram_dq), .DRAM_ADDR(dram_addr_a), .DRAM_LDQM(dram_ldqm_a),
    .DRAM_UDQM(dram_udqm_a), .DRAM_WE_N(dram_we_n_a), .DRAM_CAS_N(dram_cas_n_a),
    .DRAM_RAS_N(dram_ras_n_a), .DRAM_CS_N(dram_cs_n_a), .DRAM_BA_0(dram_ba_0_a),
    .DRAM_BA_1(dram_ba_1_a), .DRAM_CLK(dram_clk_a), .DRAM_CKE(dram_cke_a),
    .FL_DQ(fl_dq), .FL_ADDR(fl_addr_a), .FL_WE_N(fl_we_n_a), .FL_RST_N(fl_rst_n_a),
    .FL_OE_N(fl_oe_n_a), .FL_CE_N(fl_ce_n_a),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr_a), .SRAM_UB_N(sram_ub_n_a),
    .SRAM_LB_N(sram_lb_n_a), .SRAM_WE_N(sram_we_n_a), .SRAM_CE_N(sram_ce_n_a),
    .SRAM_OE_N(sram_oe_n_a),
    .SD_DAT(sd_dat), .SD_DAT3(sd_dat3), .SD_CMD(sd_cmd), .SD_CLK(sd_clk_a),
    .I2C_SDAT(i2c_sdat), .I2C_SCLK(i2c_sclk_a), .PS2_DAT(1'b1), .PS2_CLK(1'b1),
    .TDI(1'b0), .TCK(1'b0), .TCS(1'b0), .TDO(tdo_a),
    .VGA_HS(vga_hs_a), .VGA_VS(vga_vs_a), .VGA_R(vga_r_a), .VGA_G(vga_g_a), .VGA_B(vga_b_a),
    .AUD_ADCLRCK(aud_adclrck), .AUD_ADCDAT(1'b0), .AUD_DACLRCK(aud_daclrck),
    .AUD_DACDAT(aud_dacdat_a), .AUD_BCLK(aud_bclk), .AUD_XCK(aud_xck_a),
    .GPIO_0(gpio_0), .GPIO_1(gpio_1)
  );

  cii_starter_top #(.PRESCALE(1)) u_dut_b (
    .CLOCK_24({1'b0, clk}), .CLOCK_27(2'b00), .CLOCK_50(1'b0), .EXT_CLOCK(1'b0),
    .KEY({3'b111, key0}), .SW(sw),
    .HEX0(hex0_b), .HEX1(hex1_b), .HEX2(hex2_b), .HEX3(hex3_b), .LEDG(ledg_b), .LEDR(ledr_b),
    .UART_TXD(uart_txd_b), .UART_RXD(1'b1),
    .DRAM_DQ(dram_dq), .DRAM_ADDR(dram_addr_b), .DRAM_LDQM(dram_ldqm_b),
    .DRAM_UDQM(dram_udqm_b), .DRAM_WE_N(dram_we_n_b), .DRAM_CAS_N(dram_cas_n_b),
    .DRAM_RAS_N(dram_ras_n_b), .DRAM_CS_N(dram_cs_n_b), .DRAM_BA_0(dram_ba_0_b),
    .DRAM_BA_1(dram_ba_1_b), .DRAM_CLK(dram_clk_b), .DRAM_CKE(dram_cke_b),
    .FL_DQ(fl_dq), .FL_ADDR(fl_addr_b), .FL_WE_N(fl_we_n_b), .FL_RST_N(fl_rst_n_b),
    .FL_OE_N(fl_oe_n_b), .FL_CE_N(fl_ce_n_b),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr_b), .SRAM_UB_N(sram_ub_n_b),
    .SRAM_LB_N(sram_lb_n_b), .SRAM_WE_N(sram_we_n_b), .SRAM_CE_N(sram_ce_n_b),
    .SRAM_OE_N(sram_oe_n_b),
    .SD_DAT(sd_dat), .SD_DAT3(sd_dat3), .SD_CMD(sd_cmd), .SD_CLK(sd_clk_b),
    .I2C_SDAT(i2c_sdat), .I2C_SCLK(i2c_sclk_b), .PS2_DAT(1'b1), .PS2_CLK(1'b1),
    .TDI(1'b0), .TCK(1'b0), .TCS(1'b0), .TDO(tdo_b),
    .VGA_HS(vga_hs_b), .VGA_VS(vga_vs_b), .VGA_R(vga_r_b), .VGA_G(vga_g_b), .VGA_B(vga_b_b),
    .AUD_ADCLRCK(aud_adclrck), .AUD_ADCDAT(1'b0), .AUD_DACLRCK(aud_daclrck),
    .AUD_DACDAT(aud_dacdat_b), .AUD_BCLK(aud_bclk), .AUD_XCK(aud_xck_b),
    .GPIO_0(gpio_0), .GPIO_1(gpio_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: counting starts on the 3rd edge after KEY[0] rises; hold seen 2 edges late.
  always @(posedge clk or negedge key0) begin
    if (!key0) begin
      rel = 0; ev = 0; disp_ev = 0; hq = 2'b00;
    end else begin
      if (rel >= 2) begin
        disp_ev = ev;
        if (!hq[1]) ev = ev + 1;
        hq = {hq[0], sw[9]};
      end else begin
        hq = 2'b00;
      end
      if (rel < 2) rel = rel + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [15:0] v, input int n);
    logic [3:0] nib;
    nib = v[4*n +: 4];
    return seg_tbl[nib];
  endfunction

  task automatic check_disp();
    logic [15:0] ca, cb;
    ca = 16'((disp_ev / 4) % 65536);
    cb = 16'(disp_ev % 65536);
    check_eq("ledg_a", 32'(ledg_a), 32'(ca[7:0]));
    check_eq("hex0_a", 32'(hex0_a), 32'(seg_of(ca, 0)));
    check_eq("hex1_a", 32'(hex1_a), 32'(seg_of(ca, 1)));
    check_eq("hex2_a", 32'(hex2_a), 32'(seg_of(ca, 2)));
    check_eq("hex3_a", 32'(hex3_a), 32'(seg_of(ca, 3)));
    check_eq("ledg_b", 32'(ledg_b), 32'(cb[7:0]));
    check_eq("hex0_b", 32'(hex0_b), 32'(seg_of(cb, 0)));
    check_eq("hex1_b", 32'(hex1_b), 32'(seg_of(cb, 1)));
    check_eq("hex2_b", 32'(hex2_b), 32'(seg_of(cb, 2)));
    check_eq("hex3_b", 32'(hex3_b), 32'(seg_of(cb, 3)));
  endtask

  task automatic step_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_disp();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic hold_state;
    key0 = 1'b0;
    sw   = 10'h000;

    // Reset state and tie-offs
    repeat (3) @(negedge clk);
    check_eq("rst_hex0", 32'(hex0_a), 32'h40);
    check_eq("rst_hex3", 32'(hex3_a), 32'h40);
    check_eq("rst_ledg", 32'(ledg_a), 32'h0);
    check_eq("uart_txd", 32'(uart_txd_a), 32'h1);
    check_eq("dram_cs_n", 32'(dram_cs_n_a), 32'h1);
    check_eq("tdo", 32'(tdo_a), 32'h0);
    check_eq("dram_cke", 32'(dram_cke_a), 32'h0);
    check_eq("fl_rst_n", 32'(fl_rst_n_a), 32'h1);
    check_eq("sram_addr", 32'(sram_addr_a), 32'h0);
    check_disp();

    // PRESCALE=4: 50 edges after internal reset release -> count 12
    key0 = 1'b1;
    repeat (2) @(posedge clk);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_eq("p4_ledg", 32'(ledg_a), 32'h0C);
    check_eq("p4_hex0", 32'(hex0_a), 32'h46);
    check_eq("p4_hex1", 32'(hex1_a), 32'h40);
    check_eq("p4_hex3", 32'(hex3_a), 32'h40);
    check_disp();

    // Deterministic hold: freeze then resume
    sw = 10'h200;
    step_chk(10);
    sw = 10'h000;
    step_chk(10);

    // Randomized switches with occasional hold toggles; LEDR mirror checked each change
    hold_state = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check_disp();
      if ($urandom_range(0, 19) == 0) hold_state = ~hold_state;
      sw = 10'($urandom);
      sw[9] = hold_state;
      #1;
      check_eq("ledr", 32'(ledr_a), 32'(sw));
    end
    sw = 10'h2A5;
    #1;
    check_eq("ledr_2a5", 32'(ledr_b), 32'h2A5);
    @(negedge clk);
    sw = 10'h000;

    // Asynchronous reset while counting (count 5 on instance A)
    key0 = 1'b0;
    @(negedge clk);
    key0 = 1'b1;
    guard = 0;
    while (disp_ev != 20 && guard < 200) begin
      @(negedge clk);
      check_disp();
      guard++;
    end
    check_eq("mid_reach", 32'(guard < 200), 32'h1);
    check_eq("mid_pre_ledg", 32'(ledg_a), 32'h05);
    #2;
    key0 = 1'b0;
    #1;
    check_eq("mid_ledg_a", 32'(ledg_a), 32'h0);
    check_eq("mid_ledg_b", 32'(ledg_b), 32'h0);
    check_eq("mid_hex0_a", 32'(hex0_a), 32'h40);

    // Digit sweep 0..F on instance B, then full 16-bit wrap
    @(negedge clk);
    key0 = 1'b1;
    step_chk(22);
    guard = 0;
    while (disp_ev != 65536 && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("wrap_reach", 32'(guard < 70000), 32'h1);
    check_eq("wrap_ledg_b", 32'(ledg_b), 32'h0);
    check_eq("wrap_hex0_b", 32'(hex0_b), 32'h40);
    check_eq("wrap_hex1_b", 32'(hex1_b), 32'h40);
    check_eq("wrap_hex2_b", 32'(hex2_b), 32'h40);
    check_eq("wrap_hex3_b", 32'(hex3_b), 32'h40);
    check_eq("wrap_hex3_a", 32'(hex3_a), 32'h19);
    check_disp();
    step_chk(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cii_starter_top.md
# cii_starter_top

Top level of the Cyclone II Starter (DE1) board. It runs a prescaled 16-bit event counter from the 24 MHz board clock. The counter value is shown on the four seven-segment digits and its low byte on the green LEDs. The switches are mirrored on the red LEDs, and every unused board interface is parked in a safe, inactive state. The block is the root of the FPGA design; no logic sits above it.

## Interface
- `PRESCALE`, 24_000_000: clock cycles per counter tick (1 Hz at 24 MHz); range 1..2^25.
- `CLOCK_24`  in  2  24 MHz; `CLOCK_24[0]` is the only clock used; `[1]` is ignored.
- `KEY`  in  4  push buttons, active-low. `KEY[0]` is reset: asynchronous, active-low. `KEY[3:1]` are ignored.
- `CLOCK_27[1:0]`, `CLOCK_50`, `EXT_CLOCK`, `UART_RXD`, `PS2_DAT`, `PS2_CLK`, `TDI`, `TCK`, `TCS`, `AUD_ADCDAT`  in  1..2  ignored.
- `SW`  in  10  toggle switches. `SW[9]` = hold; `SW[9:0]` are also mirrored to `LEDR`.
- `HEX0..HEX3`  out  7 each  seven-segment digits, active-low, bit0 = segment a … bit6 = segment g.
- `LEDG`  out  8  counter bits [7:0].
- `LEDR`  out  10  equal to `SW`, combinational.
- `UART_TXD` out 1, constant 1. `TDO` out 1, constant 0. `VGA_HS`, `VGA_VS`, `VGA_R`, `VGA_G`, `VGA_B` out, constant 0.
- DRAM outputs: `DRAM_CS_N`, `DRAM_RAS_N`, `DRAM_CAS_N`, `DRAM_WE_N`, `DRAM_LDQM`, `DRAM_UDQM` = 1; `DRAM_CKE`, `DRAM_CLK`, `DRAM_BA_0`, `DRAM_BA_1`, `DRAM_ADDR` = 0.
- Flash outputs: `FL_CE_N`, `FL_OE_N`, `FL_WE_N`, `FL_RST_N` = 1; `FL_ADDR` = 0.
- SRAM outputs: `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` = 1; `SRAM_ADDR` = 0.
- `DRAM_DQ`, `FL_DQ`, `SRAM_DQ`, `SD_DAT`, `SD_DAT3`, `SD_CMD`, `SD_CLK`, `I2C_SDAT`, `I2C_SCLK`, `AUD_ADCLRCK`, `AUD_DACLRCK`, `AUD_DACDAT`, `AUD_BCLK`, `AUD_XCK`, `GPIO_0[35:0]`, `GPIO_1[35:0]`  inout/out  high-Z at all times.

## Operation
- The prescaler `pre` is a 25-bit register that counts 0 … `PRESCALE`−1 and then wraps.
- The tick `tick` is asserted when `pre == PRESCALE−1`, not held, and the clock edge is active.
- The counter `cnt` is 16 bits and increments by 1 on each tick. It wraps from 16'hFFFF to 16'h0000.
- Hold: while `SW[9]` = 1, both `pre` and `cnt` freeze. `SW[9]` is sampled through a 2-flop synchronizer, so the hold takes effect 2 cycles after the switch changes.
- Display mapping:
  - `HEXn` = seg(`cnt[4n+3:4n]`).
  - `LEDG` = `cnt[7:0]`.
- Segment codes (active-low), 0–F in order: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- All display outputs are registered: each `HEXn` and `LEDG` updates 1 cycle after `cnt` changes.
- Pass-through and constants: `LEDR`, the tie-off outputs and the high-Z pins do not depend on clock or reset.

## Timing
- Reset (`KEY[0]` = 0, asynchronous):
  - `pre`, `cnt` and the synchronizer flops = 0.
  - `HEX0..HEX3` = 7'h40 (digit "0").
  - `LEDG` = 0.
- Reset release is synchronized: a 2-flop reset synchronizer deasserts internal reset on the 2nd rising edge after `KEY[0]` rises.
- After internal reset deasserts, with hold = 0:
  - `cnt` = floor(N / `PRESCALE`) after N rising edges.
  - The display shows the new value one edge later.
- `PRESCALE` = 1: `cnt` increments every cycle.
- Reset asserted mid-count: all state clears immediately, with no partial tick.

## Structure
- Package `cii_starter_pkg` holds:
  - the 16-entry seven-segment constant array `SEG7_LUT`;
  - the tie-off constants.
- Sub-module `hex7seg`: 4-bit input, 7-bit registered output, clock, async active-low reset (reset value 7'h40). It is instantiated four times.
- Prescaler, counter and synchronizers live in the top level.

## Test plan
- Hold `KEY[0]` = 0 for 3 cycles -> `HEX0..HEX3` = 7'h40, `LEDG` = 0, `UART_TXD` = 1, `DRAM_CS_N` = 1, `GPIO_0` = Z.
- `PRESCALE` = 4: release reset, then 50 cycles after internal reset deasserts -> `cnt` = 12, `LEDG` = 8'h0C, `HEX0` = 7'h46, `HEX1..HEX3` = 7'h40.
- `SW` = 10'h2A5 -> `LEDR` = 10'h2A5 in the same delta cycle. `SW[9]` = 1 -> `cnt` stops changing after 2 cycles; it resumes when `SW[9]` returns to 0.
- `PRESCALE` = 1, run 65536 cycles -> `cnt` wraps to 0, all digits 7'h40.
- Pull `KEY[0]` low mid-count (`cnt` = 5) -> `cnt` and `LEDG` = 0 without waiting for a clock edge.
- Sweep `cnt` 0–F -> `HEX0` matches each `SEG7_LUT` entry.
